// File: rtl/pickup_tracker_pkg.sv
// Shared types and helpers for the multi-item pickup tracker.
package pickup_tracker_pkg;

    typedef enum logic [1:0] {PK_VISIBLE, PK_DWELL, PK_HIDDEN} pickup_state_t;

    localparam int DEF_ITEM_W = 24;
    localparam int DEF_ITEM_H = 24;

    // Channel count is capped at 8, so an 8-bit popcount covers every build.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int b = 0; b < 8; b++) begin
            c = c + 4'(v[b]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pickup_tracker_if.sv
// Player position bundle: top-left x/y of the player sprite.
interface pos_if #(
    parameter int POS_W = 12
);
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;

    modport master (output x, output y);
    modport slave  (input x, input y);
endinterface

// File: rtl/pickup_tracker_channel.sv
// One collectible: dwell debounce, idle-timeout relocate and respawn delay.
module pickup_channel
    import pickup_tracker_pkg::*;
#(
    parameter int DWELL_CYCLES   = 10_000,
    parameter int TIMEOUT_CYCLES = 1_300_000_000,
    parameter int RESPAWN_CYCLES = 65_000_000
)(
    input  logic clk,
    input  logic rst,
    input  logic game_rst,
    input  logic i_overlap,
    output logic o_take_nxt,
    output logic o_visible,
    output logic o_taken,
    output logic o_relocate
);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(RESPAWN_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HIDE_LAST = HW'(RESPAWN_CYCLES - 1);

    pickup_state_t r_state;
    logic [DW-1:0] r_dwell;
    logic [TW-1:0] r_tmo;
    logic [HW-1:0] r_hide;

    // Exposed early so the top can score takes on the same edge they register.
    assign o_take_nxt = (r_state == PK_DWELL) && i_overlap && (r_dwell >= DWELL_MAX);

    always_ff @(posedge clk) begin
        if (!rst || game_rst) begin
            r_state    <= PK_VISIBLE;
            r_dwell    <= '0;
            r_tmo      <= '0;
            r_hide     <= '0;
            o_visible  <= 1'b1;
            o_taken    <= 1'b0;
            o_relocate <= 1'b0;
        end else begin
            o_taken    <= 1'b0;
            o_relocate <= 1'b0;
            unique case (r_state)
                PK_VISIBLE: begin
                    if (i_overlap) begin
                        r_state <= PK_DWELL;
                        r_dwell <= DW'(1);
                        r_tmo   <= '0;
                    end else if (r_tmo == TMO_LAST) begin
                        o_relocate <= 1'b1;
                        r_tmo      <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                PK_DWELL: begin
                    if (!i_overlap) begin
                        r_state <= PK_VISIBLE;
                        r_dwell <= '0;
                        r_tmo   <= '0;
                    end else if (o_take_nxt) begin
                        r_state   <= PK_HIDDEN;
                        r_dwell   <= '0;
                        r_hide    <= '0;
                        o_taken   <= 1'b1;
                        o_visible <= 1'b0;
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
                PK_HIDDEN: begin
                    if (r_hide == HIDE_LAST) begin
                        r_state    <= PK_VISIBLE;
                        r_hide     <= '0;
                        o_relocate <= 1'b1;
                        o_visible  <= 1'b1;
                    end else begin
                        r_hide <= r_hide + HW'(1);
                    end
                end
                default: r_state <= PK_VISIBLE;
            endcase
        end
    end

endmodule

// File: rtl/pickup_tracker.sv
// N-channel pickup tracker: per-item hitbox test, channel FSMs, shared score and goal pulse.
module pickup_tracker
    import pickup_tracker_pkg::*;
#(
    parameter int N_ITEMS        = 4,
    parameter int POS_W          = 12,
    parameter int PLAYER_W       = 32,
    parameter int PLAYER_H       = 32,
    parameter int ITEM_W         = DEF_ITEM_W,
    parameter int ITEM_H         = DEF_ITEM_H,
    parameter int MARGIN         = 5,
    parameter int DWELL_CYCLES   = 10_000,
    parameter int TIMEOUT_CYCLES = 1_300_000_000,
    parameter int RESPAWN_CYCLES = 65_000_000,
    parameter int GOAL           = 10
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     game_rst,
    pos_if.slave                     playerpos,
    input  logic [N_ITEMS*POS_W-1:0] item_x,
    input  logic [N_ITEMS*POS_W-1:0] item_y,
    output logic [N_ITEMS-1:0]       item_visible,
    output logic [N_ITEMS-1:0]       taken,
    output logic [N_ITEMS-1:0]       relocate_req,
    output logic [7:0]               score,
    output logic                     goal_reached
);
    // Extra headroom so coordinate + box size never wraps in the compares.
    localparam int EW = POS_W + 16;
    localparam logic [8:0] GOAL9 = 9'(GOAL);

    logic [EW-1:0]      w_px;
    logic [EW-1:0]      w_py;
    logic [N_ITEMS-1:0] w_overlap;
    logic [N_ITEMS-1:0] w_take_nxt;
    logic [7:0]         r_score;
    logic               r_goal;

    assign w_px = EW'(playerpos.x);
    assign w_py = EW'(playerpos.y);

    for (genvar i = 0; i < N_ITEMS; i++) begin : g_chan
        logic [EW-1:0] w_ix;
        logic [EW-1:0] w_iy;
        assign w_ix = EW'(item_x[i*POS_W +: POS_W]);
        assign w_iy = EW'(item_y[i*POS_W +: POS_W]);
        assign w_overlap[i] = (w_px < w_ix + EW'(ITEM_W - MARGIN)) &&
                              (w_ix + EW'(MARGIN) < w_px + EW'(PLAYER_W)) &&
                              (w_py < w_iy + EW'(ITEM_H - MARGIN)) &&
                              (w_iy + EW'(MARGIN) < w_py + EW'(PLAYER_H));

        pickup_channel #(
            .DWELL_CYCLES   (DWELL_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .RESPAWN_CYCLES (RESPAWN_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .game_rst   (game_rst),
            .i_overlap  (w_overlap[i]),
            .o_take_nxt (w_take_nxt[i]),
            .o_visible  (item_visible[i]),
            .o_taken    (taken[i]),
            .o_relocate (relocate_req[i])
        );
    end

    // Returns {goal_hit, new_score}; overflow past GOAL carries into the next round.
    function automatic logic [8:0] score_step(input logic [7:0] s, input logic [3:0] k);
        logic [8:0] sum;
        sum = {1'b0, s} + {5'b0, k};
        if (sum >= GOAL9) begin
            return {1'b1, 8'(sum - GOAL9)};
        end
        return {1'b0, sum[7:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || game_rst) begin
            r_score <= '0;
            r_goal  <= 1'b0;
        end else begin
            {r_goal, r_score} <= score_step(r_score, popcount8(8'(w_take_nxt)));
        end
    end

    assign score        = r_score;
    assign goal_reached = r_goal;

endmodule

// File: tb/tb_pickup_tracker.sv
// Directed bench for pickup_tracker: 3 items, dwell 4, timeout 20, respawn 8, goal 3.
module tb_pickup_tracker;
    localparam int N  = 3;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          game_rst;
    logic [N*PW-1:0] item_x;
    logic [N*PW-1:0] item_y;
    logic [N-1:0]  item_visible;
    logic [N-1:0]  taken;
    logic [N-1:0]  relocate_req;
    logic [7:0]    score;
    logic          goal_reached;

    int n_checks = 0;
    int n_errors = 0;

    pos_if #(.POS_W(PW)) pp ();

    pickup_tracker #(
        .N_ITEMS(N), .POS_W(PW), .PLAYER_W(32), .PLAYER_H(32),
        .ITEM_W(24), .ITEM_H(24), .MARGIN(5),
        .DWELL_CYCLES(4), .TIMEOUT_CYCLES(20), .RESPAWN_CYCLES(8), .GOAL(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .game_rst     (game_rst),
        .playerpos    (pp),
        .item_x       (item_x),
        .item_y       (item_y),
        .item_visible (item_visible),
        .taken        (taken),
        .relocate_req (relocate_req),
        .score        (score),
        .goal_reached (goal_reached)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic place(input logic [PW-1:0] x, input logic [PW-1:0] y);
        pp.x = x;
        pp.y = y;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // item0 at (100,100); items 1 and 2 sit close so one player box can cover both
        item_x   = {12'd310, 12'd300, 12'd100};
        item_y   = {12'd100, 12'd100, 12'd100};
        rst      = 1'b0;
        game_rst = 1'b0;
        place(12'd1000, 12'd1000);
        tick(2);
        chk("rst_visible", 32'(item_visible), 32'h7);
        chk("rst_taken",   32'(taken),        32'h0);
        chk("rst_reloc",   32'(relocate_req), 32'h0);
        chk("rst_score",   32'(score),        32'h0);
        chk("rst_goal",    32'(goal_reached), 32'h0);
        rst = 1'b1;

        // Hold on item 0: take on the fifth overlapping edge, respawn 8 edges later
        place(12'd100, 12'd100);
        tick(4);
        chk("t1_no_take_yet", 32'(taken), 32'h0);
        chk("t1_vis_before",  32'(item_visible), 32'h7);
        tick(1);
        chk("t1_taken", 32'(taken), 32'h1);
        chk("t1_score", 32'(score), 32'h1);
        chk("t1_vis",   32'(item_visible), 32'h6);
        chk("t1_goal",  32'(goal_reached), 32'h0);
        place(12'd1000, 12'd1000);
        tick(1);
        chk("t1_pulse_once", 32'(taken), 32'h0);
        tick(6);
        chk("t1_reloc_early", 32'(relocate_req[0]), 32'h0);
        chk("t1_hidden",      32'(item_visible[0]), 32'h0);
        tick(1);
        chk("t1_respawn_reloc", 32'(relocate_req[0]), 32'h1);
        chk("t1_respawn_vis",   32'(item_visible[0]), 32'h1);

        // Broken contact restarts the dwell
        place(12'd100, 12'd100);
        tick(2);
        chk("t2_short", 32'(taken), 32'h0);
        place(12'd1000, 12'd1000);
        tick(1);
        chk("t2_leave", 32'(taken), 32'h0);
        place(12'd100, 12'd100);
        tick(4);
        chk("t2_redwell", 32'(taken), 32'h0);
        tick(1);
        chk("t2_taken", 32'(taken), 32'h1);
        chk("t2_score", 32'(score), 32'h2);
        place(12'd1000, 12'd1000);

        // Two simultaneous takes from score 2 -> goal, score wraps to 1
        place(12'd300, 12'd100);
        tick(4);
        chk("t4_wait", 32'(taken), 32'h0);
        tick(1);
        chk("t4_taken", 32'(taken), 32'h6);
        chk("t4_goal",  32'(goal_reached), 32'h1);
        chk("t4_score", 32'(score), 32'h1);
        place(12'd1000, 12'd1000);
        tick(1);
        chk("t4_goal_pulse", 32'(goal_reached), 32'h0);

        // game_rst while every item is hidden
        game_rst = 1'b1;
        tick(1);
        game_rst = 1'b0;
        chk("grh_visible", 32'(item_visible), 32'h7);
        chk("grh_score",   32'(score),        32'h0);
        chk("grh_taken",   32'(taken),        32'h0);
        chk("grh_reloc",   32'(relocate_req), 32'h0);
        chk("grh_goal",    32'(goal_reached), 32'h0);

        // Idle timeout on all channels at 20 and 40
        tick(19);
        chk("t3_reloc_19", 32'(relocate_req), 32'h0);
        tick(1);
        chk("t3_reloc_20", 32'(relocate_req), 32'h7);
        chk("t3_score",    32'(score), 32'h0);
        tick(1);
        chk("t3_reloc_21", 32'(relocate_req), 32'h0);
        tick(18);
        chk("t3_reloc_39", 32'(relocate_req), 32'h0);
        tick(1);
        chk("t3_reloc_40", 32'(relocate_req), 32'h7);

        // game_rst mid-dwell clears the dwell count
        place(12'd100, 12'd100);
        tick(2);
        game_rst = 1'b1;
        tick(1);
        game_rst = 1'b0;
        chk("grd_visible", 32'(item_visible), 32'h7);
        chk("grd_taken",   32'(taken),        32'h0);
        chk("grd_reloc",   32'(relocate_req), 32'h0);
        tick(4);
        chk("grd_wait", 32'(taken), 32'h0);
        tick(1);
        chk("grd_taken_after", 32'(taken), 32'h1);
        chk("grd_score",       32'(score), 32'h1);

        // rst with item 0 hidden and item 1 mid-dwell
        place(12'd280, 12'd100);
        tick(2);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("rstm_visible", 32'(item_visible), 32'h7);
        chk("rstm_score",   32'(score),        32'h0);
        chk("rstm_taken",   32'(taken),        32'h0);
        chk("rstm_reloc",   32'(relocate_req), 32'h0);
        chk("rstm_goal",    32'(goal_reached), 32'h0);
        tick(4);
        chk("rstm_wait", 32'(taken), 32'h0);
        tick(1);
        chk("rstm_taken_after", 32'(taken), 32'h2);
        chk("rstm_score_after", 32'(score), 32'h1);

        // Player stays on item 1 through respawn: re-dwell, take again
        tick(7);
        chk("t6_hidden_taken", 32'(taken), 32'h0);
        chk("t6_hidden_vis",   32'(item_visible[1]), 32'h0);
        tick(1);
        chk("t6_respawn_reloc", 32'(relocate_req[1]), 32'h1);
        chk("t6_respawn_vis",   32'(item_visible[1]), 32'h1);
        chk("t6_respawn_taken", 32'(taken), 32'h0);
        tick(4);
        chk("t6_redwell", 32'(taken), 32'h0);
        tick(1);
        chk("t6_taken", 32'(taken), 32'h2);
        chk("t6_score", 32'(score), 32'h2);

        // Hitbox edges: touching the shrunken box is not an overlap
        game_rst = 1'b1;
        tick(1);
        game_rst = 1'b0;
        place(12'd73, 12'd100);
        tick(6);
        chk("edge_left", 32'(taken), 32'h0);
        place(12'd119, 12'd100);
        tick(6);
        chk("edge_right", 32'(taken), 32'h0);
        place(12'd100, 12'd119);
        tick(6);
        chk("edge_bottom", 32'(taken), 32'h0);
        place(12'd100, 12'd73);
        tick(6);
        chk("edge_top", 32'(taken), 32'h0);
        place(12'd118, 12'd74);
        tick(4);
        chk("edge_inner_wait", 32'(taken), 32'h0);
        tick(1);
        chk("edge_inner_take", 32'(taken), 32'h1);
        chk("edge_inner_score", 32'(score), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
